// File: rtl/sar_pkg.sv
// Shared constants, state encoding and sizing helper for the SAR conversion sequencer.
package sar_pkg;

    localparam int NBITS_DEF         = 8;
    localparam int SAMPLE_CYCLES_DEF = 4;
    localparam int SETTLE_CYCLES_DEF = 1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SAMPLE = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_DECIDE = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_SAMPLE = ST_SAMPLE,
        S_SETTLE = ST_SETTLE,
        S_DECIDE = ST_DECIDE,
        S_DONE   = ST_DONE
    } state_t;

    // The timer holds at most max(SAMPLE,SETTLE)-1; never narrower than one bit.
    function automatic int timer_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/sar_if.sv
// Control/result bundle between the SAR sequencer and the analog front end.
interface sar_if import sar_pkg::*; #(parameter int NBITS = NBITS_DEF) ();

    // START is a one-cycle request with no ready: it is taken only when the
    // sequencer is idle; a START at any other time is dropped and flags OVR.
    logic             START;
    logic             CMP;
    logic             CLR_OVR;
    logic             SAMPLE;
    logic [NBITS-1:0] DAC;
    logic             BUSY;
    logic             EOC;
    logic [NBITS-1:0] DATA;
    logic             OVR;
    state_t           dbg_state;

    modport master (
        input  START, CMP, CLR_OVR,
        output SAMPLE, DAC, BUSY, EOC, DATA, OVR, dbg_state
    );

    modport slave (
        output START, CMP, CLR_OVR,
        input  SAMPLE, DAC, BUSY, EOC, DATA, OVR, dbg_state
    );

endinterface

// File: rtl/sar_timer.sv
// Loadable down-counter that saturates at zero; shared by the sample and settle phases.
module sar_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/sar_sequencer.sv
// Successive-approximation controller: sample, then settle/decide once per bit MSB-first.
module sar_sequencer import sar_pkg::*; #(
    parameter int NBITS         = NBITS_DEF,
    parameter int SAMPLE_CYCLES = SAMPLE_CYCLES_DEF,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input  logic CK,
    input  logic RST,
    sar_if.master bus
);

    localparam int KW = $clog2(NBITS);
    localparam int TW = timer_width(SAMPLE_CYCLES, SETTLE_CYCLES);

    state_t           state, state_n;
    logic [KW-1:0]    k, k_n, k_dn;
    logic [NBITS-1:0] dac, dac_n, data, data_n;
    logic             ovr, ovr_n;
    logic             sample_q, busy_q, eoc_q;
    logic             tmr_load, tmr_zero;
    logic [TW-1:0]    tmr_val;

    sar_timer #(.W(TW)) u_timer (
        .clk      (CK),
        .rst      (RST),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    assign k_dn = k - KW'(1);

    always_comb begin
        state_n  = state;
        k_n      = k;
        dac_n    = dac;
        data_n   = data;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            S_IDLE: begin
                dac_n = '0;
                if (bus.START) begin
                    state_n  = S_SAMPLE;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(SAMPLE_CYCLES - 1);
                end
            end
            S_SAMPLE: begin
                if (tmr_zero) begin
                    state_n            = S_SETTLE;
                    dac_n              = '0;
                    dac_n[NBITS-1]     = 1'b1;
                    k_n                = KW'(NBITS - 1);
                    tmr_load           = 1'b1;
                    tmr_val            = TW'(SETTLE_CYCLES - 1);
                end
            end
            S_SETTLE: begin
                if (tmr_zero) state_n = S_DECIDE;
            end
            S_DECIDE: begin
                // Keep or drop the trial bit, then either try the next bit or finish.
                dac_n[k] = bus.CMP;
                if (k != '0) begin
                    dac_n[k_dn] = 1'b1;
                    k_n         = k_dn;
                    tmr_load    = 1'b1;
                    tmr_val     = TW'(SETTLE_CYCLES - 1);
                    state_n     = S_SETTLE;
                end else begin
                    data_n  = {dac[NBITS-1:1], bus.CMP};
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
                dac_n   = '0;
            end
            default: begin
                state_n = S_IDLE;
                dac_n   = '0;
            end
        endcase
    end

    // A set from an ignored START outranks a same-cycle clear.
    always_comb begin
        ovr_n = ovr;
        if (bus.START && (state != S_IDLE)) begin
            ovr_n = 1'b1;
        end else if (bus.CLR_OVR) begin
            ovr_n = 1'b0;
        end
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            state    <= S_IDLE;
            k        <= '0;
            dac      <= '0;
            data     <= '0;
            ovr      <= 1'b0;
            sample_q <= 1'b0;
            busy_q   <= 1'b0;
            eoc_q    <= 1'b0;
        end else begin
            state    <= state_n;
            k        <= k_n;
            dac      <= dac_n;
            data     <= data_n;
            ovr      <= ovr_n;
            sample_q <= (state_n == S_SAMPLE);
            busy_q   <= (state_n != S_IDLE);
            eoc_q    <= (state_n == S_DONE);
        end
    end

    assign bus.SAMPLE    = sample_q;
    assign bus.DAC       = dac;
    assign bus.BUSY      = busy_q;
    assign bus.EOC       = eoc_q;
    assign bus.DATA      = data;
    assign bus.OVR       = ovr;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_sar_sequencer.sv
// Bench for sar_sequencer: default instance plus a SAMPLE=1/SETTLE=3 instance for back-to-back timing.
module tb_sar_sequencer;
  import sar_pkg::*;

  localparam int N    = 8;
  localparam int SC_A = 4;
  localparam int ST_A = 1;
  localparam int SC_B = 1;
  localparam int ST_B = 3;
  localparam int E_A  = 1 + SC_A + N * (ST_A + 1);
  localparam int E_B  = 1 + SC_B + N * (ST_B + 1);

  logic       clk;
  logic       rst;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_pass = 0;
  logic [7:0] vin_a = 8'h00;
  logic [7:0] vin_b = 8'h00;
  logic [7:0] exp_data_a = 8'h00;
  logic       exp_ovr_a = 1'b0;
  logic [7:0] exp_q[$];

  sar_if #(.NBITS(N)) bus_a ();
  sar_if #(.NBITS(N)) bus_b ();

  // Ideal comparator: keep the trial bit while Vin >= Vdac.
  assign bus_a.CMP = (vin_a >= bus_a.DAC);
  assign bus_b.CMP = (vin_b >= bus_b.DAC);

  sar_sequencer #(.NBITS(N), .SAMPLE_CYCLES(SC_A), .SETTLE_CYCLES(ST_A)) dut_a (
    .CK  (clk),
    .RST (rst),
    .bus (bus_a.master)
  );

  sar_sequencer #(.NBITS(N), .SAMPLE_CYCLES(SC_B), .SETTLE_CYCLES(ST_B)) dut_b (
    .CK  (clk),
    .RST (rst),
    .bus (bus_b.master)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d required=finish", cyc);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver + reference model ----------------
  // One conversion on instance A; optional extra START / CLR_OVR pulses at offsets from the real START.
  task automatic run_conversion(input logic [7:0] vin, input int inj1, input int inj2,
                                input int clr1, input int clr2);
    logic [7:0] tr[N];
    logic [7:0] code, trial, e_dac;
    logic       e_samp, e_busy, e_eoc, start_in, clr_in;
    int         rel;
    code = 8'h00;
    for (int b = N - 1; b >= 0; b--) begin
      trial = code | (8'd1 << b);
      tr[N - 1 - b] = trial;
      if (vin >= trial) code = trial;
    end
    vin_a = vin;
    exp_q.push_back(code);
    for (int r = 0; r <= E_A + 1; r++) begin
      start_in = (r == 0) || (r == inj1) || (r == inj2);
      clr_in = (r == clr1) || (r == clr2);
      bus_a.START = start_in;
      bus_a.CLR_OVR = clr_in;
      step();
      if (start_in && r != 0) exp_ovr_a = 1'b1;
      else if (clr_in) exp_ovr_a = 1'b0;
      rel = r + 1;
      e_samp = (rel <= SC_A);
      e_busy = (rel <= E_A);
      e_eoc = (rel == E_A);
      if (rel > SC_A && rel < E_A) e_dac = tr[(rel - SC_A - 1) / (ST_A + 1)];
      else if (rel == E_A) e_dac = code;
      else e_dac = 8'h00;
      if (rel == E_A) begin
        n_chk++;
        if (exp_q.size() == 0) $display("FAIL conv_scoreboard rel=%0d got=empty required=entry", rel);
        else begin
          exp_data_a = exp_q.pop_front();
          n_pass++;
        end
      end
      n_chk++;
      if (bus_a.SAMPLE !== e_samp) $display("FAIL conv_sample vin=%h rel=%0d got=%b exp=%b", vin, rel, bus_a.SAMPLE, e_samp);
      else n_pass++;
      n_chk++;
      if (bus_a.BUSY !== e_busy) $display("FAIL conv_busy vin=%h rel=%0d got=%b exp=%b", vin, rel, bus_a.BUSY, e_busy);
      else n_pass++;
      n_chk++;
      if (bus_a.EOC !== e_eoc) $display("FAIL conv_eoc vin=%h rel=%0d got=%b exp=%b", vin, rel, bus_a.EOC, e_eoc);
      else n_pass++;
      n_chk++;
      if (bus_a.DAC !== e_dac) $display("FAIL conv_dac vin=%h rel=%0d got=%h exp=%h", vin, rel, bus_a.DAC, e_dac);
      else n_pass++;
      n_chk++;
      if (bus_a.DATA !== exp_data_a) $display("FAIL conv_data vin=%h rel=%0d got=%h exp=%h", vin, rel, bus_a.DATA, exp_data_a);
      else n_pass++;
      n_chk++;
      if (bus_a.OVR !== exp_ovr_a) $display("FAIL conv_ovr vin=%h rel=%0d got=%b exp=%b", vin, rel, bus_a.OVR, exp_ovr_a);
      else n_pass++;
    end
    bus_a.START = 1'b0;
    bus_a.CLR_OVR = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    n_chk++;
    if (bus_a.dbg_state !== S_IDLE) $display("FAIL reset_state got=%0d exp=%0d", bus_a.dbg_state, S_IDLE);
    else n_pass++;
    n_chk++;
    if ({bus_a.SAMPLE, bus_a.BUSY, bus_a.EOC, bus_a.OVR} !== 4'b0000)
      $display("FAIL reset_flags got=%b exp=0000", {bus_a.SAMPLE, bus_a.BUSY, bus_a.EOC, bus_a.OVR});
    else n_pass++;
    n_chk++;
    if ({bus_a.DAC, bus_a.DATA} !== 16'h0000) $display("FAIL reset_codes got=%h exp=0000", {bus_a.DAC, bus_a.DATA});
    else n_pass++;
    n_chk++;
    if ({bus_b.BUSY, bus_b.EOC, bus_b.OVR, bus_b.DATA} !== 11'd0)
      $display("FAIL reset_b got=%h exp=000", {bus_b.BUSY, bus_b.EOC, bus_b.OVR, bus_b.DATA});
    else n_pass++;
  endtask

  task automatic test_directed();
    while (cyc < 10) step();
    run_conversion(8'hA5, -1, -1, -1, -1);
  endtask

  task automatic test_extremes();
    run_conversion(8'h00, -1, -1, -1, -1);
    run_conversion(8'hFF, -1, -1, -1, -1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      run_conversion(8'($urandom_range(0, 255)), -1, -1, -1, -1);
      if ($urandom_range(0, 1) == 1) step();
    end
  endtask

  task automatic test_overrun();
    run_conversion(8'($urandom_range(0, 255)), 5, E_A, -1, -1);
  endtask

  task automatic test_clr_ovr();
    run_conversion(8'($urandom_range(0, 255)), 5, -1, 5, 6);
  endtask

  task automatic test_reset_mid();
    vin_a = 8'($urandom_range(1, 255));
    for (int r = 0; r < 12; r++) begin
      bus_a.START = (r == 0) || (r == 5);
      step();
    end
    bus_a.START = 1'b0;
    n_chk++;
    if ({bus_a.dbg_state, bus_a.OVR} !== {S_DECIDE, 1'b1})
      $display("FAIL mid_pre got=%0d/%b exp=%0d/1", bus_a.dbg_state, bus_a.OVR, S_DECIDE);
    else n_pass++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_data_a = 8'h00;
    exp_ovr_a = 1'b0;
    n_chk++;
    if (bus_a.dbg_state !== S_IDLE) $display("FAIL mid_state got=%0d exp=%0d", bus_a.dbg_state, S_IDLE);
    else n_pass++;
    for (int r = 0; r < 15; r++) begin
      n_chk++;
      if ({bus_a.SAMPLE, bus_a.BUSY, bus_a.EOC, bus_a.OVR, bus_a.DAC, bus_a.DATA} !== 20'd0)
        $display("FAIL mid_idle r=%0d got=%b%b%b%b/%h/%h exp=0000/00/00", r, bus_a.SAMPLE, bus_a.BUSY,
                 bus_a.EOC, bus_a.OVR, bus_a.DAC, bus_a.DATA);
      else n_pass++;
      step();
    end
    run_conversion(8'($urandom_range(0, 255)), -1, -1, -1, -1);
  endtask

  task automatic test_back_to_back();
    logic [7:0] code, trial;
    int n;
    int timeout;
    for (int j = 0; j < 3; j++) begin
      vin_b = 8'($urandom_range(0, 255));
      code = 8'h00;
      for (int b = N - 1; b >= 0; b--) begin
        trial = code | (8'd1 << b);
        if (vin_b >= trial) code = trial;
      end
      n = cyc;
      bus_b.START = 1'b1;
      step();
      bus_b.START = 1'b0;
      timeout = 0;
      while (bus_b.EOC !== 1'b1 && timeout < 100) begin
        step();
        timeout++;
      end
      n_chk++;
      if (cyc - n !== E_B) $display("FAIL b2b_latency j=%0d got=%0d exp=%0d", j, cyc - n, E_B);
      else n_pass++;
      n_chk++;
      if (bus_b.DATA !== code) $display("FAIL b2b_data j=%0d vin=%h got=%h exp=%h", j, vin_b, bus_b.DATA, code);
      else n_pass++;
      step();
      n_chk++;
      if ({bus_b.EOC, bus_b.BUSY, bus_b.OVR} !== 3'b000)
        $display("FAIL b2b_idle j=%0d got=%b exp=000", j, {bus_b.EOC, bus_b.BUSY, bus_b.OVR});
      else n_pass++;
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst = 1'b1;
    bus_a.START = 1'b0;
    bus_a.CLR_OVR = 1'b0;
    bus_b.START = 1'b0;
    bus_b.CLR_OVR = 1'b0;
    test_reset();
    test_directed();
    test_extremes();
    test_random();
    test_overrun();
    test_clr_ovr();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
